core_memory_arbiter: RTL and testbench
======================================

# core_memory_arbiter

Shares the core's single external memory interface between the instruction-fetch port (read-only) and the load/store data port. The data port is fed by the misaligned-access splitter. The block locks a grant for the full duration of one bus access and returns data, fault and breakpoint status only to the granted requester. An optional watchdog converts a hung access into an access fault.

## Interface
- TIMEOUT_CYCLES, 0, consecutive busy cycles before a forced fault; 0 disables the watchdog; max 65535
- clk  in  1  core clock
- rst  in  1  reset, synchronous, active-high
- fetch_memoryAddress  in  32  fetch word address
- fetch_memoryReadEnable  in  1  fetch request
- fetch_memoryDataRead  out  32  read data; 0 unless fetch completes
- fetch_memoryBusy  out  1  fetch stall
- fetch_memoryAccessFault  out  1  fault on completion
- fetch_addressBreakpoint  out  1  breakpoint on completion
- data_memoryAddress  in  32  data address
- data_memoryByteSelect  in  4  byte lanes
- data_memoryWriteEnable  in  1  data write request
- data_memoryReadEnable  in  1  data read request
- data_memoryDataWrite  in  32  write data
- data_memoryDataRead  out  32  read data; 0 unless data completes
- data_memoryBusy  out  1  data stall
- data_memoryAccessFault  out  1  fault on completion
- data_addressBreakpoint  out  1  breakpoint on completion
- external_memoryAddress / ByteSelect / WriteEnable / ReadEnable / DataWrite  out  32/4/1/1/32  shared bus request
- external_memoryDataRead  in  32; external_memoryBusy  in  1; external_memoryAccessFault  in  1; external_addressBreakpoint  in  1

## Operation
- Request: X_req = readEnable | writeEnable. Requester holds address, lanes and data stable until its busy is low.
- States:
  - IDLE to GRANT_FETCH or GRANT_DATA when any request is present.
  - GRANT_* to IDLE on completion, request withdrawal or timeout.
- Tie-break in IDLE: data wins.
- External outputs:
  - GRANT_DATA: data port fields are passed through.
  - GRANT_FETCH: fetch address, lanes 4'hF, write 0, read 1.
  - IDLE: all zero.
- Completion: granted state, external enable high and external_memoryBusy low. Read data, accessFault and addressBreakpoint are routed to the granted port in that cycle only. The other port sees 0.
- X_memoryBusy = X_req & ~(granted to X & completing). A request not yet granted therefore stalls.
- Withdrawal: requester drops enable before completion. The external enables drop in the same cycle and the state goes to IDLE the next cycle; no fault is reported.
- Watchdog (TIMEOUT_CYCLES > 0):
  - A 16-bit counter counts cycles in GRANT_* with external busy high.
  - When the count reaches TIMEOUT_CYCLES, the access completes that cycle with accessFault=1, busy low and data 0.
  - The counter clears on every state change.

## Timing
- Request first seen in IDLE at cycle N: grant registered at N+1. External enable is driven from N+1.
- Minimum latency from request to completion is 1 cycle (external busy low at N+1).
- One mandatory IDLE cycle follows every completion. Back-to-back accesses from one requester therefore issue every 2 cycles at best.
- Reset:
  - State IDLE, counter 0, last-served = DATA.
  - All external outputs 0.
  - Port read data, fault and breakpoint outputs 0; busy equals the requester's own enable.
- Reset mid-access: external enables drop the same cycle, no completion is signalled and the grant is lost.
- Simultaneous requests in IDLE are resolved by the tie-break (see Configuration). The loser stays busy throughout.
- A request arriving during a grant waits, busy high, until the IDLE cycle.

## Configuration
- ARBITER_ROUND_ROBIN_EN:
  - Defined: a last-served register (updated on completion or timeout) picks the requester not served last on a tie. The first tie after reset goes to fetch.
  - Undefined: fixed priority, data always wins ties, and no last-served register exists.

## Structure
- Package core_memory_arbiter_pkg:
  - State encoding: IDLE=2'd0, GRANT_FETCH=2'd1, GRANT_DATA=2'd2.
  - Requester IDs: FETCH=1'b0, DATA=1'b1.
  - Counter width constant: 16.
- Sub-module memory_timeout_counter:
  - Inputs: enable, clear, limit.
  - Output: expired.
  - Tied off to never expire when TIMEOUT_CYCLES=0.

## Test plan
- Fetch read 0x100, external busy 2 cycles, data 0xDEADBEEF: fetch_memoryDataRead=0xDEADBEEF on completion cycle, data port sees 0, external lanes 4'hF.
- Both request at cycle N:
  - Fixed priority: data granted at N+1, fetch granted after data completion plus one IDLE cycle.
  - With ARBITER_ROUND_ROBIN_EN: fetch granted first, then data.
- Data write 0x200, lanes 4'b0011, external accessFault=1 on completion: data_memoryAccessFault=1 for one cycle, fetch fault stays 0.
- TIMEOUT_CYCLES=8, external busy stuck high: completion with accessFault=1 on the 8th busy cycle, then state IDLE.
- rst asserted during GRANT_DATA with external busy high: next cycle all external enables 0 and state IDLE; data port stays busy while its request is held.

Source files
------------

// File: rtl/core_memory_arbiter_pkg.sv
// Shared types and constants for the core memory arbiter.
package core_memory_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle       = 2'd0,
    StGrantFetch = 2'd1,
    StGrantData  = 2'd2
  } arb_state_e;

  localparam logic ReqFetch = 1'b0;
  localparam logic ReqData  = 1'b1;

  localparam int unsigned CounterWidth = 16;

endpackage

// File: rtl/memory_timeout_counter.sv
// Watchdog for a granted bus access: expires on the limit-th consecutive enabled cycle.
// A limit of zero never expires.
module memory_timeout_counter
  import core_memory_arbiter_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    clear,
  input  logic [CounterWidth-1:0] limit,
  output logic                    expired
);

  logic [CounterWidth-1:0] count_q, count_d;

  // count_q holds the number of earlier busy cycles, so the limit-th one fires.
  assign expired = enable && (limit != '0) && (count_q == limit - 1'b1);

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (limit != '0) && !expired) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/core_memory_arbiter.sv
// Arbitrates the single external memory bus between instruction fetch and load/store.
// Define ARBITER_ROUND_ROBIN_EN for round-robin tie-break instead of data-first priority.
module core_memory_arbiter
  import core_memory_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,

  input  logic [31:0] fetch_memoryAddress,
  input  logic        fetch_memoryReadEnable,
  output logic [31:0] fetch_memoryDataRead,
  output logic        fetch_memoryBusy,
  output logic        fetch_memoryAccessFault,
  output logic        fetch_addressBreakpoint,

  input  logic [31:0] data_memoryAddress,
  input  logic [3:0]  data_memoryByteSelect,
  input  logic        data_memoryWriteEnable,
  input  logic        data_memoryReadEnable,
  input  logic [31:0] data_memoryDataWrite,
  output logic [31:0] data_memoryDataRead,
  output logic        data_memoryBusy,
  output logic        data_memoryAccessFault,
  output logic        data_addressBreakpoint,

  output logic [31:0] external_memoryAddress,
  output logic [3:0]  external_memoryByteSelect,
  output logic        external_memoryWriteEnable,
  output logic        external_memoryReadEnable,
  output logic [31:0] external_memoryDataWrite,
  input  logic [31:0] external_memoryDataRead,
  input  logic        external_memoryBusy,
  input  logic        external_memoryAccessFault,
  input  logic        external_addressBreakpoint
);

  localparam logic [CounterWidth-1:0] TimeoutLimit = CounterWidth'(TIMEOUT_CYCLES);

  arb_state_e state_q, state_d;

  logic fetch_req, data_req;
  logic ext_en, complete, timeout_expired;
  logic fetch_complete, data_complete;
  logic tie_to_fetch;

  assign fetch_req = fetch_memoryReadEnable;
  assign data_req  = data_memoryReadEnable | data_memoryWriteEnable;

`ifdef ARBITER_ROUND_ROBIN_EN
  logic last_served_q;

  assign tie_to_fetch = (last_served_q == ReqData);

  always_ff @(posedge clk) begin
    if (rst) begin
      last_served_q <= ReqData;
    end else if (complete) begin
      last_served_q <= (state_q == StGrantData) ? ReqData : ReqFetch;
    end
  end
`else
  assign tie_to_fetch = 1'b0;
`endif

  // Bus request mux; enables follow the live request so withdrawal or reset drops them at once.
  always_comb begin
    external_memoryAddress     = '0;
    external_memoryByteSelect  = '0;
    external_memoryWriteEnable = 1'b0;
    external_memoryReadEnable  = 1'b0;
    external_memoryDataWrite   = '0;
    if (!rst) begin
      case (state_q)
        StGrantData: begin
          external_memoryAddress     = data_memoryAddress;
          external_memoryByteSelect  = data_memoryByteSelect;
          external_memoryWriteEnable = data_memoryWriteEnable;
          external_memoryReadEnable  = data_memoryReadEnable;
          external_memoryDataWrite   = data_memoryDataWrite;
        end
        StGrantFetch: begin
          external_memoryAddress    = fetch_memoryAddress;
          external_memoryByteSelect = 4'hF;
          external_memoryReadEnable = fetch_req;
        end
        default: ;
      endcase
    end
  end

  assign ext_en         = external_memoryReadEnable | external_memoryWriteEnable;
  assign complete       = ext_en & (~external_memoryBusy | timeout_expired);
  assign fetch_complete = complete & (state_q == StGrantFetch);
  assign data_complete  = complete & (state_q == StGrantData);

  memory_timeout_counter u_timeout (
    .clk     (clk),
    .rst     (rst),
    .enable  (ext_en & external_memoryBusy),
    .clear   (state_d != state_q),
    .limit   (TimeoutLimit),
    .expired (timeout_expired)
  );

  // A timed-out access returns a fault with no data and no breakpoint.
  always_comb begin
    fetch_memoryDataRead    = (fetch_complete && !timeout_expired) ? external_memoryDataRead : '0;
    fetch_memoryAccessFault = fetch_complete & (timeout_expired | external_memoryAccessFault);
    fetch_addressBreakpoint = fetch_complete & ~timeout_expired & external_addressBreakpoint;
    fetch_memoryBusy        = fetch_req & ~fetch_complete;
    data_memoryDataRead     = (data_complete && !timeout_expired) ? external_memoryDataRead : '0;
    data_memoryAccessFault  = data_complete & (timeout_expired | external_memoryAccessFault);
    data_addressBreakpoint  = data_complete & ~timeout_expired & external_addressBreakpoint;
    data_memoryBusy         = data_req & ~data_complete;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (data_req && !(fetch_req && tie_to_fetch)) begin
          state_d = StGrantData;
        end else if (fetch_req) begin
          state_d = StGrantFetch;
        end
      end
      StGrantFetch: if (complete || !fetch_req) state_d = StIdle;
      StGrantData:  if (complete || !data_req) state_d = StIdle;
      default:      state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: tb/tb_core_memory_arbiter.sv
// Scoreboard bench for core_memory_arbiter with a programmable external memory responder.
module tb_core_memory_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] fetch_memoryAddress;
  logic        fetch_memoryReadEnable;
  logic [31:0] fetch_memoryDataRead;
  logic        fetch_memoryBusy, fetch_memoryAccessFault, fetch_addressBreakpoint;
  logic [31:0] data_memoryAddress;
  logic [3:0]  data_memoryByteSelect;
  logic        data_memoryWriteEnable, data_memoryReadEnable;
  logic [31:0] data_memoryDataWrite;
  logic [31:0] data_memoryDataRead;
  logic        data_memoryBusy, data_memoryAccessFault, data_addressBreakpoint;
  logic [31:0] external_memoryAddress;
  logic [3:0]  external_memoryByteSelect;
  logic        external_memoryWriteEnable, external_memoryReadEnable;
  logic [31:0] external_memoryDataWrite;
  logic [31:0] external_memoryDataRead;
  logic        external_memoryBusy, external_memoryAccessFault, external_addressBreakpoint;

  int          busy_cycles;
  logic [31:0] resp_data;
  logic        resp_fault, resp_bp;
  int          resp_cnt;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        is_data;
    logic [31:0] rdata;
    logic        fault;
    logic        bp;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  core_memory_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk                        (clk),
    .rst                        (rst),
    .fetch_memoryAddress        (fetch_memoryAddress),
    .fetch_memoryReadEnable     (fetch_memoryReadEnable),
    .fetch_memoryDataRead       (fetch_memoryDataRead),
    .fetch_memoryBusy           (fetch_memoryBusy),
    .fetch_memoryAccessFault    (fetch_memoryAccessFault),
    .fetch_addressBreakpoint    (fetch_addressBreakpoint),
    .data_memoryAddress         (data_memoryAddress),
    .data_memoryByteSelect      (data_memoryByteSelect),
    .data_memoryWriteEnable     (data_memoryWriteEnable),
    .data_memoryReadEnable      (data_memoryReadEnable),
    .data_memoryDataWrite       (data_memoryDataWrite),
    .data_memoryDataRead        (data_memoryDataRead),
    .data_memoryBusy            (data_memoryBusy),
    .data_memoryAccessFault     (data_memoryAccessFault),
    .data_addressBreakpoint     (data_addressBreakpoint),
    .external_memoryAddress     (external_memoryAddress),
    .external_memoryByteSelect  (external_memoryByteSelect),
    .external_memoryWriteEnable (external_memoryWriteEnable),
    .external_memoryReadEnable  (external_memoryReadEnable),
    .external_memoryDataWrite   (external_memoryDataWrite),
    .external_memoryDataRead    (external_memoryDataRead),
    .external_memoryBusy        (external_memoryBusy),
    .external_memoryAccessFault (external_memoryAccessFault),
    .external_addressBreakpoint (external_addressBreakpoint)
  );

  // Responder: busy for busy_cycles cycles of a live access, then ready.
  wire ext_en = external_memoryReadEnable | external_memoryWriteEnable;
  assign external_memoryBusy        = ext_en && (resp_cnt < busy_cycles);
  assign external_memoryDataRead    = resp_data;
  assign external_memoryAccessFault = resp_fault;
  assign external_addressBreakpoint = resp_bp;

  always @(posedge clk) begin
    if (!ext_en) resp_cnt <= 0;
    else if (external_memoryBusy) resp_cnt <= resp_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Monitor: pops one expectation per completion seen on either port.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      logic f_ev, d_ev;
      exp_t e;
      f_ev = fetch_memoryReadEnable & ~fetch_memoryBusy;
      d_ev = (data_memoryReadEnable | data_memoryWriteEnable) & ~data_memoryBusy;
      if (f_ev || d_ev) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_completion: got fetch=%0b data=%0b expected none", f_ev, d_ev);
        end else begin
          e = exp_q.pop_front();
          check("completing_port", {31'b0, d_ev}, {31'b0, e.is_data});
          if (d_ev) begin
            check("data_rdata", data_memoryDataRead, e.rdata);
            check("data_fault", {31'b0, data_memoryAccessFault}, {31'b0, e.fault});
            check("data_bp", {31'b0, data_addressBreakpoint}, {31'b0, e.bp});
            check("fetch_quiet", {fetch_memoryDataRead[30:0], fetch_memoryAccessFault}, 32'h0);
          end else begin
            check("fetch_rdata", fetch_memoryDataRead, e.rdata);
            check("fetch_fault", {31'b0, fetch_memoryAccessFault}, {31'b0, e.fault});
            check("fetch_bp", {31'b0, fetch_addressBreakpoint}, {31'b0, e.bp});
            check("data_quiet", {data_memoryDataRead[30:0], data_memoryAccessFault}, 32'h0);
          end
        end
      end else if ((fetch_memoryDataRead | data_memoryDataRead) != 0 || fetch_memoryAccessFault ||
                   data_memoryAccessFault || fetch_addressBreakpoint || data_addressBreakpoint) begin
        checks++;
        errors++;
        $display("FAIL spurious_response: got fdata=%h ddata=%h expected zero",
                 fetch_memoryDataRead, data_memoryDataRead);
      end
    end
  end

  task automatic set_resp(input int bc, input logic [31:0] d, input logic f, input logic b);
    busy_cycles = bc;
    resp_data   = d;
    resp_fault  = f;
    resp_bp     = b;
  endtask

  task automatic push(input logic is_data, input logic [31:0] d, input logic f, input logic b);
    exp_t e;
    e.is_data = is_data;
    e.rdata   = d;
    e.fault   = f;
    e.bp      = b;
    exp_q.push_back(e);
  endtask

  // Single-requester access; checks grant-cycle bus fields, latency and the trailing idle cycle.
  task automatic run_access(input string name, input logic is_data, input logic we,
                            input logic [31:0] addr, input logic [3:0] lanes,
                            input int exp_cycles);
    int   c;
    logic done;
    c = 0;
    done = 1'b0;
    if (is_data) begin
      data_memoryAddress     = addr;
      data_memoryByteSelect  = lanes;
      data_memoryDataWrite   = 32'hA5A5_0000 | addr;
      data_memoryWriteEnable = we;
      data_memoryReadEnable  = ~we;
    end else begin
      fetch_memoryAddress    = addr;
      fetch_memoryReadEnable = 1'b1;
    end
    while (!done && c < 40) begin
      @(posedge clk); #1;
      c++;
      if (c == 1) begin
        check({name, "_addr"}, external_memoryAddress, addr);
        check({name, "_lanes"}, {28'b0, external_memoryByteSelect},
              {28'b0, (is_data ? lanes : 4'hF)});
        check({name, "_we_re"}, {30'b0, external_memoryWriteEnable, external_memoryReadEnable},
              {30'b0, we, ~we});
        if (we) check({name, "_wdata"}, external_memoryDataWrite, 32'hA5A5_0000 | addr);
      end
      if (is_data) done = ~data_memoryBusy;
      else         done = ~fetch_memoryBusy;
    end
    check({name, "_latency"}, c, exp_cycles);
    @(posedge clk); #1;
    check({name, "_idle_after"}, {31'b0, ext_en}, 32'h0);
    fetch_memoryReadEnable = 1'b0;
    data_memoryWriteEnable = 1'b0;
    data_memoryReadEnable  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    int d_done, f_done;
    logic drop_d, drop_f;
    rst = 1'b1;
    fetch_memoryAddress    = '0;
    fetch_memoryReadEnable = 1'b1;
    data_memoryAddress     = '0;
    data_memoryByteSelect  = '0;
    data_memoryWriteEnable = 1'b0;
    data_memoryReadEnable  = 1'b0;
    data_memoryDataWrite   = '0;
    set_resp(0, 32'h0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_ext_en", {31'b0, ext_en}, 32'h0);
    check("rst_ext_addr", external_memoryAddress, 32'h0);
    check("rst_fetch_busy", {31'b0, fetch_memoryBusy}, 32'h1);
    check("rst_data_busy", {31'b0, data_memoryBusy}, 32'h0);
    check("rst_fetch_rdata", fetch_memoryDataRead, 32'h0);
    fetch_memoryReadEnable = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    set_resp(2, 32'hDEAD_BEEF, 1'b0, 1'b0);
    push(1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    run_access("fetch_read", 1'b0, 1'b0, 32'h100, 4'hF, 3);

    set_resp(1, 32'hCAFE_0001, 1'b1, 1'b0);
    push(1'b1, 32'hCAFE_0001, 1'b1, 1'b0);
    run_access("data_write_fault", 1'b1, 1'b1, 32'h200, 4'b0011, 2);

    // Simultaneous requests: data write to 0x500, fetch from 0x600.
    set_resp(0, 32'h55AA_55AA, 1'b0, 1'b0);
`ifdef ARBITER_ROUND_ROBIN_EN
    push(1'b0, 32'h55AA_55AA, 1'b0, 1'b0);
    push(1'b1, 32'h55AA_55AA, 1'b0, 1'b0);
`else
    push(1'b1, 32'h55AA_55AA, 1'b0, 1'b0);
    push(1'b0, 32'h55AA_55AA, 1'b0, 1'b0);
`endif
    data_memoryAddress     = 32'h500;
    data_memoryByteSelect  = 4'hF;
    data_memoryWriteEnable = 1'b1;
    fetch_memoryAddress    = 32'h600;
    fetch_memoryReadEnable = 1'b1;
    d_done = 0; f_done = 0; drop_d = 1'b0; drop_f = 1'b0;
    for (int c = 1; c <= 20 && (d_done == 0 || f_done == 0); c++) begin
      @(posedge clk); #1;
      if (drop_d) begin data_memoryWriteEnable = 1'b0; drop_d = 1'b0; end
      if (drop_f) begin fetch_memoryReadEnable = 1'b0; drop_f = 1'b0; end
`ifdef ARBITER_ROUND_ROBIN_EN
      if (c == 1) check("tie_first_addr", external_memoryAddress, 32'h600);
`else
      if (c == 1) check("tie_first_addr", external_memoryAddress, 32'h500);
`endif
      if (data_memoryWriteEnable && !data_memoryBusy) begin d_done = c; drop_d = 1'b1; end
      if (fetch_memoryReadEnable && !fetch_memoryBusy) begin f_done = c; drop_f = 1'b1; end
    end
    @(posedge clk); #1;
    data_memoryWriteEnable = 1'b0;
    fetch_memoryReadEnable = 1'b0;
`ifdef ARBITER_ROUND_ROBIN_EN
    check("tie_fetch_cycle", f_done, 1);
    check("tie_data_cycle", d_done, 3);
`else
    check("tie_data_cycle", d_done, 1);
    check("tie_fetch_cycle", f_done, 3);
`endif
    @(posedge clk); #1;

    set_resp(0, 32'h0BAD_F00D, 1'b0, 1'b1);
    push(1'b0, 32'h0BAD_F00D, 1'b0, 1'b1);
    run_access("fetch_bp", 1'b0, 1'b0, 32'h700, 4'hF, 1);

    set_resp(1000, 32'h1111_2222, 1'b0, 1'b0);
    push(1'b1, 32'h0, 1'b1, 1'b0);
    run_access("timeout", 1'b1, 1'b0, 32'h300, 4'hF, 8);

    // Withdrawal: fetch drops its request mid-access; no completion expected.
    fetch_memoryAddress    = 32'h800;
    fetch_memoryReadEnable = 1'b1;
    @(posedge clk); #1;
    check("wd_granted", {31'b0, external_memoryReadEnable}, 32'h1);
    @(posedge clk); #1;
    fetch_memoryReadEnable = 1'b0;
    #1;
    check("wd_en_drop", {31'b0, ext_en}, 32'h0);
    @(posedge clk); #1;
    check("wd_idle", {31'b0, ext_en}, 32'h0);

    // Reset during a stuck data read.
    data_memoryAddress    = 32'h400;
    data_memoryReadEnable = 1'b1;
    @(posedge clk); #1;
    check("rstmid_granted", {31'b0, external_memoryReadEnable}, 32'h1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("rstmid_en_drop", {31'b0, ext_en}, 32'h0);
    check("rstmid_busy", {31'b0, data_memoryBusy}, 32'h1);
    @(posedge clk); #1;
    check("rstmid_after_en", {31'b0, ext_en}, 32'h0);
    check("rstmid_after_busy", {31'b0, data_memoryBusy}, 32'h1);
    data_memoryReadEnable = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    check("rstmid_idle", {31'b0, ext_en}, 32'h0);

    repeat (2) @(posedge clk);
    #1;
    check("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
